aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Iterative AES-128 key schedule that accepts a 128-bit cipher key, runs the ten FIPS-197 expansion steps one per clock, and stores all eleven round keys in an internal register file. It sits directly upstream of the AES round datapath, which reads round keys by index through a combinational read port once `keys_valid` is high.

## Interface
- No parameters. Fixed at AES-128: 4-word key, 10 rounds, 11 stored round keys.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `key_in` in 128: cipher key, FIPS-197 byte order. Word w0 = `key_in[127:96]` and w3 = `key_in[31:0]`.
- `key_valid` in 1: `key_in` is valid this cycle.
- `key_ready` out 1: block can accept a key this cycle.
- `busy` out 1: expansion in progress.
- `keys_valid` out 1: all 11 round keys are stored and stable.
- `rd_addr` in 4: round-key index, 0 to 10.
- `rd_key` out 128: round key `rd_addr`, same word order as `key_in`.

## Operation
- States: IDLE, EXPAND, READY.
- Handshake: a key is accepted on an edge where `key_valid && key_ready`.
- `key_ready` = 1 in IDLE and READY, 0 in EXPAND.
- On accept:
  - slot 0 <= `key_in`
  - working register <= `key_in`
  - round counter <= 1
  - state -> EXPAND
  - `keys_valid` <= 0
- EXPAND, each cycle with counter i (1..10):
  - t = SubWord(RotWord(w3)) ^ Rcon[i]. RotWord rotates left by one byte. SubWord applies the forward AES S-box to each byte.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Slot i and the working register both <= {w0',w1',w2',w3'}.
  - Counter increments.
  - When i = 10: state -> READY and `keys_valid` <= 1.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word; the other three bytes are zero.
- READY: keys are held indefinitely. A new accepted key restarts the sequence from slot 0. `keys_valid` drops on that same edge.
- `key_valid` while in EXPAND is ignored. It is not queued; upstream must hold it until `key_ready`.
- Read port:
  - `rd_key` = slot[`rd_addr`], combinational.
  - `rd_addr` 11 to 15 returns 128'h0.
  - Reads are permitted in any state. Slot contents are only guaranteed while `keys_valid` = 1.
- `busy` = 1 exactly when state is EXPAND.

## Timing
- Reset values:
  - state IDLE
  - `key_ready` = 1, `busy` = 0, `keys_valid` = 0
  - counter = 0
  - all slots and the working register = 0, so `rd_key` = 0 for every address
- Latency: key accepted at edge E0. `busy` is high from E0 through E10. Slot i is written at edge E(i). `keys_valid` = 1 and `key_ready` = 1 after E10, i.e. 10 cycles after acceptance.
- Minimum key-to-key spacing: 11 cycles.
- `rst` asserted during EXPAND:
  - next edge returns to IDLE
  - partial slots are cleared to 0
  - `keys_valid` stays 0
- `rst` and `key_valid` asserted together: reset wins and the key is not accepted.
- `keys_valid` never glitches high on a partially expanded schedule.
- Critical path: one S-box stage plus a 4-word XOR chain per cycle. No further pipelining.

## Test plan
- **FIPS-197 vector.** Reset, then accept key 2b7e151628aed2a6abf7158809cf4f3c. `keys_valid` must rise exactly 10 cycles later, and then:
  - `rd_addr` 0 -> 2b7e151628aed2a6abf7158809cf4f3c
  - `rd_addr` 1 -> a0fafe1788542cb123a339392a6c7605
  - `rd_addr` 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
- **Ignored mid-run key.** During EXPAND, assert `key_valid` with key 0. `key_ready` must be 0, the input is ignored, and slot 10 still matches d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Reset mid-expansion.** Assert `rst` at cycle 5 of EXPAND. Next cycle:
  - `busy` = 0, `keys_valid` = 0, `key_ready` = 1
  - `rd_addr` 3 -> 0
- **Back-to-back keys.** In READY, accept the all-zero key. `keys_valid` must drop on the accepting edge, and after 10 cycles `rd_addr` 1 -> 62636363626363636263636362636363 and `rd_addr` 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- **Out-of-range read.** `rd_addr` 11 and `rd_addr` 15 -> 128'h0 in every state.

Source files
------------

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one FIPS-197 round-key step per clock,
// all eleven round keys held in a register file with a combinational read port.
module aes_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic           keys_valid_q, keys_valid_d;
    logic           key_ready_q, busy_q;
    logic [127:0]   slots_q [0:10];

    logic           wr_en_s;
    logic [3:0]     wr_idx_s;
    logic [127:0]   wr_data_s;
    logic [127:0]   next_words_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // One expansion step on the working key.
    always_comb begin
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({work_q[23:0], work_q[31:24]}) ^ {rcon(cnt_q), 24'h000000};
        n0 = work_q[127:96] ^ t;
        n1 = work_q[95:64]  ^ n0;
        n2 = work_q[63:32]  ^ n1;
        n3 = work_q[31:0]   ^ n2;
        next_words_s = {n0, n1, n2, n3};
    end

    // Next-state, counter and slot-write decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        work_d       = work_q;
        keys_valid_d = keys_valid_q;
        wr_en_s      = 1'b0;
        wr_idx_s     = 4'd0;
        wr_data_s    = 128'h0;
        case (state_q)
            IDLE, READY: begin
                if (key_valid) begin
                    state_d      = EXPAND;
                    cnt_d        = 4'd1;
                    work_d       = key_in;
                    keys_valid_d = 1'b0;
                    wr_en_s      = 1'b1;
                    wr_idx_s     = 4'd0;
                    wr_data_s    = key_in;
                end else begin
                    state_d = state_q;
                end
            end
            EXPAND: begin
                work_d    = next_words_s;
                wr_en_s   = 1'b1;
                wr_idx_s  = cnt_q;
                wr_data_s = next_words_s;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    state_d      = READY;
                    keys_valid_d = 1'b1;
                end else begin
                    state_d = EXPAND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, control and status registers; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            work_q       <= 128'h0;
            keys_valid_q <= 1'b0;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            work_q       <= work_d;
            keys_valid_q <= keys_valid_d;
            key_ready_q  <= (state_d != EXPAND);
            busy_q       <= (state_d == EXPAND);
        end
    end

    // Round-key register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                slots_q[i] <= 128'h0;
            end
        end else if (wr_en_s) begin
            slots_q[wr_idx_s] <= wr_data_s;
        end
    end

    // Combinational read port; indices past the last round key read as zero.
    always_comb begin
        rd_key = 128'h0;
        if (rd_addr <= 4'd10) begin
            rd_key = slots_q[rd_addr];
        end else begin
            rd_key = 128'h0;
        end
    end

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: a FIPS-197 word-recurrence model
// predicts every round key; a monitor sweeps the read port when keys_valid rises.
`timescale 1ns/1ps
module tb_aes_key_schedule;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;

    aes_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_addr    (rd_addr),
        .rd_key     (rd_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int negcnt = 0;
    int mon_done = 0;
    logic [7:0] sb [256];
    logic [1407:0] exp_q [$];
    int due_q [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] m_xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = m_xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: brute-force inverse, then the bitwise affine map.
    task automatic build_sbox();
        logic [7:0] c = 8'h63;
        for (int v = 0; v < 256; v++) begin
            logic [7:0] x = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (m_mul(v[7:0], y[7:0]) == 8'h01) x = y[7:0];
            for (int i = 0; i < 8; i++)
                s[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
            sb[v] = s;
        end
    endtask

    function automatic logic [1407:0] ref_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        logic [1407:0] r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]};
                temp ^= {rc, 24'h0};
                rc = m_xtime(rc);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int k = 0; k < 11; k++) r[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return r;
    endfunction

    // Monitor: on each keys_valid rise, check latency and every read address.
    initial begin
        logic kv_prev = 1'b0;
        logic [1407:0] cur;
        int due;
        forever begin
            @(negedge clk);
            negcnt++;
            if (keys_valid === 1'b1 && !kv_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_keys_valid: got 1 expected 0 at negedge %0d", negcnt);
                end else begin
                    cur = exp_q.pop_front();
                    due = due_q.pop_front();
                    chk("keys_valid_latency", 128'(negcnt), 128'(due));
                    for (int a = 0; a < 16; a++) begin
                        rd_addr = a[3:0];
                        #1;
                        chk($sformatf("round_key_%0d", a), rd_key,
                            (a <= 10) ? cur[a*128 +: 128] : 128'h0);
                        @(negedge clk);
                        negcnt++;
                    end
                end
                mon_done++;
            end
            kv_prev = keys_valid;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [127:0] expv);
        rd_addr = a;
        #1;
        chk(nm, rd_key, expv);
    endtask

    task automatic send_key(input logic [127:0] k, input bit track);
        key_in    = k;
        key_valid = 1'b1;
        if (track) begin
            exp_q.push_back(ref_expand(k));
            due_q.push_back(negcnt + 12);
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        chk("accept_busy", 128'(busy), 128'(1));
        chk("accept_key_ready", 128'(key_ready), 128'(0));
        chk("accept_keys_valid", 128'(keys_valid), 128'(0));
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (mon_done < target && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (mon_done < target) begin
            errors++;
            $display("FAIL wait_keys_valid: got %0d schedules expected %0d", mon_done, target);
        end
    endtask

    initial begin
        logic [127:0] fips_k, fips_r1, fips_r10, zero_r1, zero_r10;
        int target = 0;
        fips_k   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_r1  = 128'h62636363626363636263636362636363;
        zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        rst = 1'b1; key_valid = 1'b0; key_in = 128'h0; rd_addr = 4'd0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_key_ready", 128'(key_ready), 128'(1));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_keys_valid", 128'(keys_valid), 128'(0));
        for (int a = 0; a < 16; a++) rd_chk($sformatf("reset_rd_%0d", a), a[3:0], 128'h0);

        // Reset and key_valid together: the key must not be taken.
        align();
        rst = 1'b1; key_valid = 1'b1; key_in = fips_k;
        align();
        rst = 1'b0; key_valid = 1'b0;
        chk("rst_vs_key_busy", 128'(busy), 128'(0));
        chk("rst_vs_key_ready", 128'(key_ready), 128'(1));
        rd_chk("rst_vs_key_rd0", 4'd0, 128'h0);

        // FIPS-197 vector with an ignored mid-run key and out-of-range reads.
        align();
        send_key(fips_k, 1'b1);
        target++;
        repeat (2) @(posedge clk);
        #1;
        key_in = 128'h0; key_valid = 1'b1;
        #1;
        chk("midrun_key_ready", 128'(key_ready), 128'(0));
        rd_chk("expand_rd_11", 4'd11, 128'h0);
        rd_chk("expand_rd_15", 4'd15, 128'h0);
        align();
        chk("midrun_key_ready_2", 128'(key_ready), 128'(0));
        key_valid = 1'b0;
        wait_done(target);
        rd_chk("fips_rd_0", 4'd0, fips_k);
        rd_chk("fips_rd_1", 4'd1, fips_r1);
        rd_chk("fips_rd_10", 4'd10, fips_r10);
        rd_chk("ready_rd_11", 4'd11, 128'h0);
        rd_chk("ready_rd_15", 4'd15, 128'h0);

        // Back-to-back: all-zero key accepted straight from READY.
        align();
        send_key(128'h0, 1'b1);
        target++;
        wait_done(target);
        rd_chk("zero_rd_1", 4'd1, zero_r1);
        rd_chk("zero_rd_10", 4'd10, zero_r10);

        // Reset during expansion.
        align();
        send_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; key_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
        align();
        rst = 1'b0; key_valid = 1'b0;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_keys_valid", 128'(keys_valid), 128'(0));
        chk("midrst_key_ready", 128'(key_ready), 128'(1));
        rd_chk("midrst_rd_3", 4'd3, 128'h0);
        rd_chk("midrst_rd_11", 4'd11, 128'h0);
        repeat (14) @(posedge clk);
        #1;
        chk("midrst_stays_invalid", 128'(keys_valid), 128'(0));

        // Random keys, some with a stray key_valid during expansion.
        for (int n = 0; n < 6; n++) begin
            align();
            send_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
            target++;
            if (n % 2 == 1) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
                key_valid = 1'b1;
                align();
                key_valid = 1'b0;
            end
            wait_done(target);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
